// File: rtl/radio_timing_pkg.sv
// Shared definitions for the radio timing generator: channel FSM states and
// the default counter width.
package radio_timing_pkg;

    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WARMUP   = 2'd1,
        RX       = 2'd2,
        RAMPDOWN = 2'd3
    } state_t;

endpackage

// File: rtl/radio_timing_chan.sv
// One radio channel: IDLE -> WARMUP -> RX -> RAMPDOWN -> IDLE with a down-counter.
// Outputs are registered decodes of the state being entered, so they track the state.
//
// Handshake: i_start is a single-cycle request taken only in IDLE; i_abort and
// i_isolate override it and end any sequence on the next edge without o_done.
module radio_timing_chan
    import radio_timing_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             i_ck,
    input  logic             i_rst_n,
    input  logic             i_isolate,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_cfg_warmup,
    input  logic [CNT_W-1:0] i_cfg_rx_len,
    output logic             o_enable,
    output logic             o_rx,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_rx_len;
    logic [CNT_W-1:0] w_rx_len_nxt;
    logic             r_enable;
    logic             r_rx;
    logic             r_busy;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_kill;

    assign w_kill = i_abort | i_isolate;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rx_len_nxt = r_rx_len;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && !w_kill) begin
                    w_state_nxt  = WARMUP;
                    // A zero warmup still spends one cycle in WARMUP.
                    w_cnt_nxt    = (i_cfg_warmup == '0) ? '0 : i_cfg_warmup - CNT_W'(1);
                    w_rx_len_nxt = i_cfg_rx_len;
                end
            end
            WARMUP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (r_rx_len == '0) begin
                    w_state_nxt = RAMPDOWN;
                end else begin
                    w_state_nxt = RX;
                    w_cnt_nxt   = r_rx_len - CNT_W'(1);
                end
            end
            RX: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = RAMPDOWN;
                end
            end
            RAMPDOWN: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_kill && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_ck) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rx_len <= '0;
            r_enable <= 1'b0;
            r_rx     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rx_len <= w_rx_len_nxt;
            r_enable <= (w_state_nxt != IDLE);
            r_rx     <= (w_state_nxt == RX);
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= w_done_nxt;
        end
    end

    assign o_enable = r_enable;
    assign o_rx     = r_rx;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_state  = r_state;

endmodule

// File: rtl/radio_timing_gen.sv
// Multi-channel radio enable / RX-window timing generator; one independent
// radio_timing_chan per channel sharing clock, reset, isolate and configuration.
module radio_timing_gen
    import radio_timing_pkg::*;
#(
    parameter int BIT_WIDTH = 2,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                   ck,
    input  logic                   rst_n,
    input  logic                   isolate,
    input  logic [BIT_WIDTH-1:0]   start,
    input  logic [BIT_WIDTH-1:0]   abort,
    input  logic [CNT_W-1:0]       cfg_warmup,
    input  logic [CNT_W-1:0]       cfg_rx_len,
    output logic [BIT_WIDTH-1:0]   radioEnableSynced,
    output logic [BIT_WIDTH-1:0]   radioRxEnSynced,
    output logic [BIT_WIDTH-1:0]   busy,
    output logic [BIT_WIDTH-1:0]   done,
    output logic [2*BIT_WIDTH-1:0] o_dbg_state
);

    for (genvar g = 0; g < BIT_WIDTH; g++) begin : g_chan
        radio_timing_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .i_ck        (ck),
            .i_rst_n     (rst_n),
            .i_isolate   (isolate),
            .i_start     (start[g]),
            .i_abort     (abort[g]),
            .i_cfg_warmup(cfg_warmup),
            .i_cfg_rx_len(cfg_rx_len),
            .o_enable    (radioEnableSynced[g]),
            .o_rx        (radioRxEnSynced[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g]),
            .o_state     (o_dbg_state[2*g+1 -: 2])
        );
    end

endmodule

// File: tb/tb_radio_timing_gen.sv
// Directed scenarios for radio_timing_gen; each cycle's expected outputs go
// into a queue that a negedge monitor pops and compares.
module tb_radio_timing_gen;

    localparam int BW   = 2;
    localparam int CW   = 8;
    localparam int MAXC = 600;

    logic            ck;
    logic            rst_n;
    logic            isolate;
    logic [BW-1:0]   start;
    logic [BW-1:0]   abort;
    logic [CW-1:0]   cfg_warmup;
    logic [CW-1:0]   cfg_rx_len;
    logic [BW-1:0]   radioEnableSynced;
    logic [BW-1:0]   radioRxEnSynced;
    logic [BW-1:0]   busy;
    logic [BW-1:0]   done;
    logic [2*BW-1:0] dbg_state;

    radio_timing_gen #(.BIT_WIDTH(BW), .CNT_W(CW)) dut (
        .ck               (ck),
        .rst_n            (rst_n),
        .isolate          (isolate),
        .start            (start),
        .abort            (abort),
        .cfg_warmup       (cfg_warmup),
        .cfg_rx_len       (cfg_rx_len),
        .radioEnableSynced(radioEnableSynced),
        .radioRxEnSynced  (radioRxEnSynced),
        .busy             (busy),
        .done             (done),
        .o_dbg_state      (dbg_state)
    );

    // Clock and watchdog
    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    int vectors;
    int miscompares;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    // Per-cycle stimulus and expected-output plan
    logic [BW-1:0] stim_start[0:MAXC];
    logic [BW-1:0] stim_abort[0:MAXC];
    logic          stim_iso  [0:MAXC];
    logic          stim_rst  [0:MAXC];
    int            cfg_w_a   [0:MAXC];
    int            cfg_r_a   [0:MAXC];
    logic [BW-1:0] exp_en    [0:MAXC];
    logic [BW-1:0] exp_rx    [0:MAXC];
    logic [BW-1:0] exp_done  [0:MAXC];

    logic [4*BW-1:0] exp_q[$];
    string           tag_q[$];

    task automatic clear_plan();
        for (int c = 0; c <= MAXC; c++) begin
            stim_start[c] = '0;
            stim_abort[c] = '0;
            stim_iso[c]   = 1'b0;
            stim_rst[c]   = 1'b1;
            cfg_w_a[c]    = 0;
            cfg_r_a[c]    = 0;
            exp_en[c]     = '0;
            exp_rx[c]     = '0;
            exp_done[c]   = '0;
        end
    endtask

    task automatic set_cfg(input int from, input int w, input int r);
        for (int c = from; c <= MAXC; c++) begin
            cfg_w_a[c] = w;
            cfg_r_a[c] = r;
        end
    endtask

    // Expected outputs of a sequence started (start sampled) in cycle s, from the
    // cycle budget: enable s+1..s+W+R+1, rx s+W+1..s+W+R, done s+W+R+2; all
    // outputs forced low from cycle 'cut' (abort, isolate or reset).
    task automatic add_seq(input int ch, input int s, input int w, input int r, input int cut);
        int we;
        we = (w == 0) ? 1 : w;
        for (int c = 0; c <= MAXC; c++) begin
            if (c < cut) begin
                if (c >= s + 1 && c <= s + we + r + 1) exp_en[c][ch] = 1'b1;
                if (c >= s + we + 1 && c <= s + we + r) exp_rx[c][ch] = 1'b1;
                if (c == s + we + r + 2) exp_done[c][ch] = 1'b1;
            end
        end
    endtask

    // Driver: applies cycle c inputs, then queues the expected outputs for cycle c+1
    task automatic run_plan(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            start      = stim_start[c];
            abort      = stim_abort[c];
            isolate    = stim_iso[c];
            rst_n      = stim_rst[c];
            cfg_warmup = CW'(cfg_w_a[c]);
            cfg_rx_len = CW'(cfg_r_a[c]);
            @(posedge ck);
            #1;
            exp_q.push_back({exp_en[c+1], exp_rx[c+1], exp_en[c+1], exp_done[c+1]});
            tag_q.push_back($sformatf("%s c%0d", name, c + 1));
        end
        start   = '0;
        abort   = '0;
        isolate = 1'b0;
        rst_n   = 1'b1;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [4*BW-1:0] exp;
        logic [4*BW-1:0] act;
        string           tag;
        forever begin
            @(negedge ck);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                act = {radioEnableSynced, radioRxEnSynced, busy, done};
                vectors++;
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL %s: got en=%b rx=%b busy=%b done=%b, expected en=%b rx=%b busy=%b done=%b",
                             tag, act[4*BW-1 -: BW], act[3*BW-1 -: BW], act[2*BW-1 -: BW], act[BW-1:0],
                             exp[4*BW-1 -: BW], exp[3*BW-1 -: BW], exp[2*BW-1 -: BW], exp[BW-1:0]);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        start       = '0;
        abort       = '0;
        isolate     = 1'b0;
        rst_n       = 1'b0;
        cfg_warmup  = '0;
        cfg_rx_len  = '0;

        // Reset with a start request that must be ignored
        clear_plan();
        for (int c = 0; c < 3; c++) stim_rst[c] = 1'b0;
        stim_start[1] = 2'b11;
        set_cfg(0, 2, 2);
        run_plan("reset", 6);

        // Nominal sequence on channel 0, channel 1 stays quiet
        clear_plan();
        set_cfg(0, 3, 4);
        stim_start[0] = 2'b01;
        add_seq(0, 0, 3, 4, MAXC + 1);
        run_plan("nominal", 12);

        // Zero warmup and RX length on channel 1
        clear_plan();
        set_cfg(0, 0, 0);
        stim_start[0] = 2'b10;
        add_seq(1, 0, 0, 0, MAXC + 1);
        run_plan("zero_len", 6);

        // Abort mid-RX, restart; abort together with start in IDLE is ignored
        clear_plan();
        set_cfg(0, 2, 10);
        stim_start[0] = 2'b01;
        stim_start[3] = 2'b10;
        stim_abort[3] = 2'b10;
        stim_abort[5] = 2'b01;
        stim_start[7] = 2'b01;
        add_seq(0, 0, 2, 10, 6);
        add_seq(0, 7, 2, 10, MAXC + 1);
        run_plan("abort", 25);

        // Isolate during RX on both channels, blocked start, restart after release
        clear_plan();
        set_cfg(0, 2, 6);
        stim_start[0] = 2'b11;
        for (int c = 4; c < 7; c++) stim_iso[c] = 1'b1;
        stim_start[5] = 2'b10;
        stim_start[8] = 2'b11;
        add_seq(0, 0, 2, 6, 5);
        add_seq(1, 0, 2, 6, 5);
        add_seq(0, 8, 2, 6, MAXC + 1);
        add_seq(1, 8, 2, 6, MAXC + 1);
        run_plan("isolate", 21);

        // Re-pulsed start ignored, start in done cycle, cfg change mid-run
        clear_plan();
        set_cfg(0, 2, 3);
        set_cfg(2, 5, 1);
        stim_start[0]  = 2'b01;
        stim_start[1]  = 2'b10;
        stim_start[3]  = 2'b11;
        stim_start[7]  = 2'b01;
        stim_start[10] = 2'b01;
        add_seq(0, 0, 2, 3, MAXC + 1);
        add_seq(1, 1, 2, 3, MAXC + 1);
        add_seq(0, 7, 5, 1, MAXC + 1);
        run_plan("overlap", 18);

        // Reset asserted mid-sequence; start during reset ignored
        clear_plan();
        set_cfg(0, 3, 4);
        stim_start[0] = 2'b01;
        stim_rst[4]   = 1'b0;
        stim_start[4] = 2'b10;
        add_seq(0, 0, 3, 4, 5);
        run_plan("reset_mid", 12);

        // Full-scale counters on channel 0, short run on channel 1 alongside
        clear_plan();
        set_cfg(0, 255, 255);
        set_cfg(2, 1, 1);
        stim_start[0] = 2'b01;
        stim_start[2] = 2'b10;
        add_seq(0, 0, 255, 255, MAXC + 1);
        add_seq(1, 2, 1, 1, MAXC + 1);
        run_plan("max_cnt", 515);

        @(negedge ck);
        @(negedge ck);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/radio_timing_gen.md
RADIO_TIMING_GEN -- requirements
Module: radio_timing_gen

Interface
REQ-001 Parameter BIT_WIDTH, default 2: number of independent radio channels.
REQ-002 Parameter CNT_W, default 8: width of the warmup and RX-window counters.
REQ-003 ck  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous to ck and active-low.
REQ-005 isolate  input  1  when high, all channels are forced idle and all outputs are driven low.
REQ-006 start  input  BIT_WIDTH  per-channel single-cycle request to run one enable/RX sequence.
REQ-007 abort  input  BIT_WIDTH  per-channel request to terminate the channel's sequence immediately.
REQ-008 cfg_warmup  input  CNT_W  warmup length in cycles, shared by all channels.
REQ-009 cfg_rx_len  input  CNT_W  RX-window length in cycles, shared by all channels.
REQ-010 radioEnableSynced  output  BIT_WIDTH  per-channel registered radio enable, driven to the radioEnable capture stage.
REQ-011 radioRxEnSynced  output  BIT_WIDTH  per-channel registered RX enable, driven to the radioRxEn capture stage.
REQ-012 busy  output  BIT_WIDTH  high while the channel is in any state other than IDLE.
REQ-013 done  output  BIT_WIDTH  one-cycle pulse on normal completion of a sequence.

Function
REQ-014 Each channel SHALL implement an independent FSM with states IDLE, WARMUP, RX and RAMPDOWN.
REQ-015 IDLE->WARMUP SHALL occur when start[i]=1 and abort[i]=0 and isolate=0; cfg_warmup and cfg_rx_len SHALL be latched into per-channel registers on that edge.
REQ-016 WARMUP SHALL last max(latched warmup,1) cycles with enable=1 and rx=0, then move to RX, or directly to RAMPDOWN if latched rx_len=0.
REQ-017 RX SHALL last latched rx_len cycles with enable=1 and rx=1, then move to RAMPDOWN.
REQ-018 RAMPDOWN SHALL last exactly 1 cycle with enable=1 and rx=0, then move to IDLE, with done[i]=1 for that first IDLE cycle.
REQ-019 All outputs SHALL be registered and SHALL decode the current state only: IDLE drives enable=0, rx=0 and busy=0.
REQ-020 Latency: with start sampled at edge 0, radioEnableSynced SHALL be high from cycle 1.
REQ-021 Cycle budget: with W=max(warmup,1) and R=rx_len, rx is high in cycles W+1..W+R, RAMPDOWN is cycle W+R+1, and done is high in cycle W+R+2.
REQ-022 start[i] while busy[i]=1 SHALL be ignored, with no queuing.
REQ-023 start and done coinciding in the same cycle SHALL start a new sequence, giving back-to-back operation.
REQ-024 abort[i] SHALL have priority over start[i]; in any non-IDLE state it SHALL force IDLE on the next edge, with enable, rx and busy low from the next cycle and no done pulse.
REQ-025 isolate=1 SHALL abort all channels as in REQ-024 and SHALL block new starts for as long as it is held.
REQ-026 Changes to cfg_* during an active sequence SHALL NOT affect that sequence.
REQ-027 Counters SHALL count down from the latched value and SHALL NOT wrap; a value of 255 with CNT_W=8 SHALL give exactly 255 cycles.

Reset
REQ-028 When rst_n=0 at a ck edge, all FSMs SHALL go to IDLE and all counters and latched cfg registers SHALL clear to 0.
REQ-029 During reset, radioEnableSynced, radioRxEnSynced, busy and done SHALL all be 0.
REQ-030 Reset asserted mid-sequence SHALL terminate the sequence without a done pulse.
REQ-031 Inputs SHALL be ignored while rst_n=0.

Structure
REQ-032 A shared package radio_timing_pkg SHALL hold the FSM state enum (IDLE, WARMUP, RX, RAMPDOWN) and the default CNT_W constant.
REQ-033 A sub-module radio_timing_chan SHALL implement one channel (FSM, counter and output registers).
REQ-034 radio_timing_gen SHALL instantiate radio_timing_chan BIT_WIDTH times in a generate loop.

Verification
REQ-035 Nominal: warmup=3, rx_len=4, start[0] at cycle 0 -> enable[0] high in cycles 1-8, rx[0] high in 4-7, done[0] in 9, channel 1 outputs stay 0.
REQ-036 Zero lengths: warmup=0, rx_len=0, start -> enable high in cycles 1-2, rx never high, done in 3.
REQ-037 Abort: warmup=2, rx_len=10, abort[0] at cycle 5 -> enable and rx low from cycle 6, no done, a start at cycle 7 is accepted.
REQ-038 Isolate: both channels in RX, isolate=1 for 3 cycles -> all outputs 0 the next cycle, a start during isolate is ignored, a start after release works.
REQ-039 Overlap: start re-pulsed while busy -> ignored; start in the done cycle -> a new sequence with no gap; cfg changed mid-run -> timing unchanged.
REQ-040 Reset mid-run: rst_n=0 at cycle 4 of the nominal case -> all outputs 0 from cycle 5, no done pulse.
